// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
//   Bundles the requester-side handshake and the APB master bus used by
//   apb_master_arbiter.
//   master modport : arbiter side (consumes requests, drives the APB bus)
//   slave modport  : environment side (requesters plus the APB slave)
//   Requester fields are packed, requester i at [i*W +: W].
//   Signals:
//     req_valid/req_addr/req_wdata/req_write/req_strb  request from requesters
//     req_ready                                        one-hot accept pulse
//     rsp_valid/rsp_rdata/rsp_err                      completion to owner
//     PSELx/PENABLE/PADDR/PWDATA/PWRITE/PSTRB          APB request side
//     PREADY/PRDATA                                    APB response side
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_write;
  logic [NREQ*NBYTES-1:0]     req_strb;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;

  logic                       PSELx;
  logic                       PENABLE;
  logic [ADDR_WIDTH-1:0]      PADDR;
  logic [DATA_WIDTH-1:0]      PWDATA;
  logic                       PWRITE;
  logic [NBYTES-1:0]          PSTRB;
  logic                       PREADY;
  logic [DATA_WIDTH-1:0]      PRDATA;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_strb, PREADY, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSELx, PENABLE, PADDR, PWDATA, PWRITE, PSTRB
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_strb, PREADY, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSELx, PENABLE, PADDR, PWDATA, PWRITE, PSTRB
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB master port between NREQ requesters with round-robin
//   arbitration. Each accepted request runs IDLE -> SETUP -> ACCESS -> IDLE;
//   the owner gets a one-cycle rsp_valid pulse (with read data) in the first
//   IDLE cycle after PREADY is sampled.
//   Ports:
//     PCLK    clock
//     PRESET  synchronous active-high reset
//     bus     apb_master_arbiter_if.master (requester handshake + APB bus)
//   Optional feature macro: APB_TIMEOUT_EN
//     defined   : ACCESS is abandoned after TIMEOUT cycles without PREADY,
//                 completing with rsp_err=1 and rsp_rdata=0.
//     undefined : ACCESS waits for PREADY indefinitely; rsp_err is tied 0.
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("apb_master_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Round-robin search: first valid requester at or after rr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Accept pulse is combinational so the requester sees it in the same IDLE
  // cycle that the request fields are latched; suppressed during reset.
  assign bus.req_ready = (state == IDLE && found && !PRESET) ?
                         (NREQ'(1) << winner) : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      rr            <= '0;
      owner         <= '0;
      bus.PSELx     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.PWRITE    <= 1'b0;
      bus.PSTRB     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      bus.rsp_err   <= 1'b0;
      to_cnt        <= '0;
`endif
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            owner       <= winner;
            rr          <= IDX_W'((int'(winner) + 1) % NREQ);
            bus.PADDR   <= bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.PWDATA  <= bus.req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            bus.PWRITE  <= bus.req_write[winner];
            // Reads never carry strobes on the bus.
            bus.PSTRB   <= bus.req_write[winner] ?
                           bus.req_strb[winner*NBYTES +: NBYTES] : '0;
            bus.PSELx   <= 1'b1;
            bus.PENABLE <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PSELx     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= NREQ'(1) << owner;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
`ifdef APB_TIMEOUT_EN
            bus.rsp_err   <= 1'b0;
`endif
            state         <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          // Limit reached on this cycle with no PREADY: abandon the transfer.
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.PSELx     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= NREQ'(1) << owner;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          bus.PSELx   <= 1'b0;
          bus.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
